// File: rtl/mips_defs.sv
// Shared MIPS definitions: bus widths, the zero word and the instruction-memory load states.
package mips_defs;
    localparam int InstBusWidth = 32;
    localparam logic [InstBusWidth-1:0] ZeroWord = '0;
    localparam int InstMemAddrWidth = 10;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_RUN  = 2'd2
    } ld_state_e;
endpackage

// File: rtl/inst_mem_loader.sv
// Byte-stream image loader: load FSM, big-endian word assembly, write pointer and status flags.
module inst_mem_loader
    import mips_defs::*;
#(
    parameter int ADDR_WIDTH = InstMemAddrWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_valid_i,
    input  logic [7:0]              ld_byte_i,
    input  logic                    ld_last_i,
    input  logic                    fault_evt_i,
    output logic                    ld_ready_o,
    output logic                    ld_done_o,
    output logic                    cpu_hold_o,
    output logic                    ld_ovf_o,
    output logic                    fetch_fault_o,
    output logic                    run_o,
    output logic [ADDR_WIDTH:0]     words_loaded_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   waddr_o,
    output logic [InstBusWidth-1:0] wdata_o
);
    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t PtrOne = ptr_t'(1);

    ld_state_e               state_q, state_d;
    ptr_t                    wptr_q, wptr_d, wl_q, wl_d, wptr_base;
    logic [1:0]              bcnt_q, bcnt_d, bcnt_base;
    logic [InstBusWidth-1:0] word_q, word_d, word_base, merged;
    logic                    ovf_q, ovf_d, fault_q, fault_d;
    logic                    done_q, done_d, hold_q, hold_d, rdy_q;
    logic                    accept, first, full, wr;

    assign accept = ld_valid_i & rdy_q;
    // Any byte arriving outside LOAD starts a fresh image.
    assign first  = accept & (state_q != LD_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LD_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) state_d = ld_last_i ? LD_RUN : LD_LOAD;
    end

    always_comb begin
        we_o    = wr;
        waddr_o = wptr_base[ADDR_WIDTH-1:0];
        wdata_o = merged;
        run_o   = (state_q == LD_RUN);
    end

    assign wptr_base = first ? '0 : wptr_q;
    assign bcnt_base = first ? 2'd0 : bcnt_q;
    assign word_base = first ? ZeroWord : word_q;
    assign full      = wptr_base[ADDR_WIDTH];
    assign merged    = word_base | (InstBusWidth'(ld_byte_i) << {~bcnt_base, 3'b000});
    assign wr        = accept & ~full & ((bcnt_base == 2'd3) | ld_last_i);

    always_comb begin
        wptr_d  = wptr_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        wl_d    = wl_q;
        ovf_d   = ovf_q;
        fault_d = first ? 1'b0 : (fault_q | fault_evt_i);
        done_d  = accept & ld_last_i;
        hold_d  = (state_d != LD_RUN);
        if (accept) begin
            wptr_d = wptr_base;
            bcnt_d = bcnt_base;
            word_d = word_base;
            wl_d   = first ? '0 : wl_q;
            ovf_d  = first ? 1'b0 : ovf_q;
            if (full) begin
                ovf_d = 1'b1;
            end else if (wr) begin
                wptr_d = wptr_base + PtrOne;
                bcnt_d = 2'd0;
                word_d = ZeroWord;
            end else begin
                bcnt_d = bcnt_base + 2'd1;
                word_d = merged;
            end
            if (ld_last_i) begin
                wl_d   = wr ? (wptr_base + PtrOne) : wptr_base;
                bcnt_d = 2'd0;
                word_d = ZeroWord;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            bcnt_q  <= 2'd0;
            word_q  <= ZeroWord;
            wl_q    <= '0;
            ovf_q   <= 1'b0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            wl_q    <= wl_d;
            ovf_q   <= ovf_d;
            fault_q <= fault_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            rdy_q   <= 1'b1;
        end
    end

    assign ld_ready_o     = rdy_q;
    assign ld_done_o      = done_q;
    assign cpu_hold_o     = hold_q;
    assign ld_ovf_o       = ovf_q;
    assign fetch_fault_o  = fault_q;
    assign words_loaded_o = wl_q;
endmodule

// File: rtl/inst_mem.sv
// Instruction memory for the mips fetch port: byte-stream loaded array with combinational read.
module inst_mem
    import mips_defs::*;
#(
    parameter int ADDR_WIDTH = InstMemAddrWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [31:0]             addr,
    output logic [InstBusWidth-1:0] ins,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_byte,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    ld_done,
    output logic                    cpu_hold,
    output logic                    ld_ovf,
    output logic                    fetch_fault
);
    localparam int Depth = 2 ** ADDR_WIDTH;

    logic [InstBusWidth-1:0] mem [Depth];
    logic                    run, we, aligned, hi_ok, in_range, fault_evt;
    logic [ADDR_WIDTH-1:0]   idx, waddr;
    logic [ADDR_WIDTH:0]     words_loaded;
    logic [InstBusWidth-1:0] wdata;

    inst_mem_loader #(.ADDR_WIDTH(ADDR_WIDTH)) u_loader (
        .clk            (clk),
        .rst            (rst),
        .ld_valid_i     (ld_valid),
        .ld_byte_i      (ld_byte),
        .ld_last_i      (ld_last),
        .fault_evt_i    (fault_evt),
        .ld_ready_o     (ld_ready),
        .ld_done_o      (ld_done),
        .cpu_hold_o     (cpu_hold),
        .ld_ovf_o       (ld_ovf),
        .fetch_fault_o  (fetch_fault),
        .run_o          (run),
        .words_loaded_o (words_loaded),
        .we_o           (we),
        .waddr_o        (waddr),
        .wdata_o        (wdata)
    );

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign idx      = addr[ADDR_WIDTH+1:2];
    assign aligned  = (addr[1:0] == 2'b00);
    assign hi_ok    = (addr[31:ADDR_WIDTH+2] == '0);
    // Words past the loaded image stay readable as NOPs without flagging a fault.
    assign in_range = ({1'b0, idx} < words_loaded);

    assign fault_evt = ce & run & (~aligned | ~hi_ok);
    assign ins       = (ce & run & aligned & hi_ok & in_range) ? mem[idx] : ZeroWord;
endmodule

// File: doc/inst_mem.md
# inst_mem

Instruction memory that serves the `mips` core's fetch port (`addr_output`/`enabler_output` → `ins_input`). A byte-stream loader fills it from a host or boot channel. While loading, it holds the core through `cpu_hold`. Reads are combinational so the core's registered PC sees its instruction in the same cycle. Writes, word assembly, the load state machine and status flags are all sequential.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `clk`, in, 1: clock; everything samples on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `ce`, in, 1: fetch enable from the core (`enabler_output`).
- `addr`, in, 32: fetch byte address from the core (`addr_output`).
- `ins`, out, 32: fetched instruction, connects to the core's `ins_input`.
- `ld_valid`, in, 1: loader byte valid.
- `ld_byte`, in, 8: loader data byte.
- `ld_last`, in, 1: marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`, out, 1: loader may transfer.
- `ld_done`, out, 1: one-cycle pulse when an image has been committed.
- `cpu_hold`, out, 1: high means the core must be held in reset.
- `ld_ovf`, out, 1: sticky flag; image exceeded the memory depth.
- `fetch_fault`, out, 1: sticky flag; a misaligned or out-of-range fetch occurred.

## Operation
- States: IDLE (after reset, nothing loaded), LOAD, RUN.
- IDLE → LOAD on an accepted byte without `ld_last`.
- IDLE or LOAD → RUN on an accepted byte with `ld_last`.
- RUN → LOAD, or RUN → RUN if that byte has `ld_last`, on any accepted byte. This is a reload.
- A byte transfers when `ld_valid & ld_ready`. `ld_ready` is 1 in every state outside reset.
- The first byte of every load (IDLE or RUN entry) does the following:
  - clears `wptr`, `bcnt`, `words_loaded`, `ld_ovf` and `fetch_fault`;
  - acts as byte 0 of word 0.
- Bytes assemble big-endian: byte 0 goes to [31:24], byte 3 to [7:0].
- When the 4th byte is accepted, the word is written to `mem[wptr]`, `wptr` increments and `bcnt` wraps to 0.
- `ld_last` on a partial word: the unfilled low bytes are zero-padded and the word is written on the same edge.
- `words_loaded` equals `wptr` after the final write.
- `wptr` == depth: further bytes are dropped and `ld_ovf` is set. `ld_last` still ends the load.
- Read:
  - `ins = mem[addr[ADDR_WIDTH+1:2]]` when `ce` and state is RUN and `addr[1:0]==0` and `addr[31:ADDR_WIDTH+2]==0` and the index < `words_loaded`.
  - In every other case `ins = 0`, which is a NOP.
- Fault: `fetch_fault` sets on an edge where `ce` and state is RUN and (`addr[1:0]!=0` or out-of-range high bits).
  - An index at or beyond `words_loaded` but within depth returns 0 and is not a fault.
- `cpu_hold` = 1 in IDLE and LOAD, 0 in RUN. It is registered.
- Memory array contents are not reset.

## Timing
- Reset values: state IDLE, `cpu_hold` 1, `ld_ready` 0 while `rst` is low and 1 from the first edge after release, `ld_done` 0, `ld_ovf` 0, `fetch_fault` 0, `ins` 0, all counters 0.
- Read latency is 0: `ins` is combinational from `addr`, `ce` and state.
- Write commits on the accepting edge. The data is readable from the next cycle (once in RUN).
- For a last byte accepted at edge N:
  - `ld_done` is high for exactly the cycle after N;
  - `cpu_hold` falls after N;
  - fetches are served from N onward.
- A reload byte in RUN at edge N raises `cpu_hold` after N. `ins` returns 0 from that cycle.
- Reset asserted mid-load: the load is abandoned immediately, counters clear and the state returns to IDLE. Partially written words remain in the array but are unreadable until the next load.

## Structure
- Shared package `mips_defs`: `ZeroWord`, `InstBusWidth` (32), the load-state enum (IDLE/LOAD/RUN) and `InstMemAddrWidth` default.
- Sub-module `inst_mem_loader`: the FSM, byte assembly, `wptr`, `bcnt`, `words_loaded` and the flags. It emits a single-cycle write strobe with address and data.
- The top level owns the array and the combinational read/fault decode.

## Test plan
- Reset release → `cpu_hold`=1, `ins`=0, `ld_ready`=1 from the next edge. Fetch `ce`=1, `addr`=0 → `ins`=0, no fault.
- Load 8 bytes 0x34,0x01,0x11,0x00,0x34,0x02,0x00,0x20 with `ld_last` on the 8th → `ld_done` pulse, `cpu_hold`=0. `addr` 0 → `ins`=0x34011100; `addr` 4 → `ins`=0x34020020; `addr` 8 → `ins`=0.
- Load 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE with the last on 0xEE → word 1 = 0xEE000000, `words_loaded`=2.
- `ADDR_WIDTH`=2, load 20 bytes → `ld_ovf`=1. Words 0–3 hold the first 16 bytes and the extra 4 bytes are dropped.
- In RUN, fetch `addr`=0x2 → `ins`=0, `fetch_fault`=1. Fetch `addr`=0x1000 with `ADDR_WIDTH`=10 → fault stays set.
- In RUN, start a reload → the cycle after the byte has `cpu_hold`=1, `fetch_fault`/`ld_ovf` cleared and `ins`=0. Assert `rst` mid-reload → state IDLE, `cpu_hold`=1.
